// File: rtl/mem_arb5_pkg.sv
// Shared definitions for the 5-requester memory arbiter: requester count,
// pointer width, FSM state encoding and small index helpers.
package mem_arb5_pkg;

  localparam int unsigned NREQ  = 5;
  localparam int unsigned PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot requester vector (0 when none is set).
  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Next requester index, wrapping modulo NREQ.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p >= PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb5_rr_pick5.sv
// Combinational round-robin picker: one-hot winner among req, searching
// upward from index ptr and wrapping modulo NREQ.
module rr_pick5
  import mem_arb5_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + 32'(k)) % NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb5.sv
// Round-robin 5-way memory arbiter with per-requester burst lock and a
// bounded beat count per grant; gnt drives the downstream one-hot mux selects.
module mem_arb5
  import mem_arb5_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CW        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic            out_valid,
  output logic [NREQ-1:0] ack,
  output logic [CW-1:0]   beat_cnt
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] rel_ptr;
  logic [PTR_W-1:0] arb_ptr;
  logic [NREQ-1:0]  win;
  logic             accept;
  logic             at_max;
  logic             rel;

  // Handshake is a pure function of the held grant and live inputs.
  assign ack       = gnt_q & req & {NREQ{out_ready}};
  assign out_valid = |(gnt_q & req);
  assign accept    = |ack;

  assign g_idx   = oh_to_idx(gnt_q);
  assign rel_ptr = ptr_inc(g_idx);
  assign at_max  = (cnt_q + CW'(1)) == CW'(MAX_BEATS);

  // One picker serves both paths: the stored pointer when idle, the
  // post-release pointer when a grant is being handed over.
  assign arb_ptr = (state_q == GRANT) ? rel_ptr : ptr_q;

  rr_pick5 u_pick (
    .req (req),
    .ptr (arb_ptr),
    .win (win)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release on abort, on an unlocked beat, or on the last allowed beat.
        rel = !(|(gnt_q & req)) ||
              (accept && (!(|(gnt_q & lock)) || at_max));
        if (rel) begin
          ptr_d   = rel_ptr;
          gnt_d   = win;
          cnt_d   = '0;
          state_d = (|req) ? GRANT : IDLE;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arb5.sv
// Directed bench for mem_arb5: stimulus pushes hand-computed per-cycle
// expectations into a queue, a negedge monitor pops and compares them.
module tb_mem_arb5;

  logic       clk;
  logic       reset;
  logic [4:0] req;
  logic [4:0] lock;
  logic       out_ready;
  logic [4:0] gnt;
  logic       out_valid;
  logic [4:0] ack;
  logic [7:0] beat_cnt;

  typedef struct packed {
    logic [4:0] gnt;
    logic [4:0] ack;
    logic [7:0] cnt;
    logic       vld;
  } exp_t;

  exp_t expq[$];
  int   checks;
  int   errors;
  int   cyc;
  int   drain_cyc;
  bit   done;

  mem_arb5 #(.MAX_BEATS(16), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .ack       (ack),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after an edge and queue what this cycle must show.
  task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] lk,
                      input logic rdy, input logic [4:0] eg, input logic [4:0] ea,
                      input logic [7:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    req       = rq;
    lock      = lk;
    out_ready = rdy;
    e.gnt = eg;
    e.ack = ea;
    e.cnt = ec;
    e.vld = |(eg & rq);
    expq.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    checks++;
    if (!$onehot0(gnt)) begin
      errors++;
      $display("FAIL gnt_onehot0 cycle %0d: got %b expected zero or one-hot", cyc, gnt);
    end
    checks++;
    if ((ack != 5'b0) && !out_valid) begin
      errors++;
      $display("FAIL ack_implies_valid cycle %0d: got ack=%b out_valid=%b", cyc, ack, out_valid);
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cmp("gnt", 32'(gnt), 32'(e.gnt));
      cmp("ack", 32'(ack), 32'(e.ack));
      cmp("beat_cnt", 32'(beat_cnt), 32'(e.cnt));
      cmp("out_valid", 32'(out_valid), 32'(e.vld));
    end
    if (done) begin
      drain_cyc++;
      if (expq.size() == 0) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (drain_cyc > 10) begin
        errors++;
        $display("FAIL drain: got %0d pending entries expected 0", expq.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    drain_cyc = 0;
    done      = 1'b0;
    reset     = 1'b1;
    req       = 5'b0;
    lock      = 5'b0;
    out_ready = 1'b0;

    // Reset holds gnt/ack/out_valid low even with requests pending.
    step(1'b1, 5'b00000, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);
    step(1'b1, 5'b00101, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);
    step(1'b0, 5'b00101, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);

    // Two unlocked requesters alternate every cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'b00101, 5'b0, 1'b1, 5'b00001, 5'b00001, 8'd0);
      step(1'b0, 5'b00101, 5'b0, 1'b1, 5'b00100, 5'b00100, 8'd0);
    end
    step(1'b0, 5'b00101, 5'b0, 1'b1, 5'b00001, 5'b00001, 8'd0);

    // Requester 2 stalled by out_ready=0; others toggle lock meanwhile.
    step(1'b0, 5'b11111, 5'b0, 1'b0, 5'b00100, 5'b00000, 8'd0);
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'b11111, (i % 2 == 1) ? 5'b11011 : 5'b00000, 1'b0,
           5'b00100, 5'b00000, 8'd0);

    // Hand over to requester 3, which then drops its request.
    step(1'b0, 5'b11111, 5'b0, 1'b1, 5'b00100, 5'b00100, 8'd0);
    step(1'b0, 5'b11111, 5'b0, 1'b0, 5'b01000, 5'b00000, 8'd0);
    step(1'b0, 5'b10111, 5'b0, 1'b1, 5'b01000, 5'b00000, 8'd0);
    step(1'b0, 5'b10111, 5'b0, 1'b0, 5'b10000, 5'b00000, 8'd0);

    // Locked burst on requester 4: 16 beats, forced release, regrant.
    for (int k = 0; k < 16; k++)
      step(1'b0, 5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 8'(k));
    step(1'b0, 5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 8'd0);
    for (int k = 1; k < 7; k++)
      step(1'b0, 5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 8'(k));

    // Reset pulsed at beat_cnt=7, then first arbitration from ptr=0.
    step(1'b1, 5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b10000, 8'd7);
    step(1'b0, 5'b11111, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);
    step(1'b0, 5'b11111, 5'b0, 1'b1, 5'b00001, 5'b00001, 8'd0);

    // Sole remaining requester re-wins after its own release; then idle.
    step(1'b0, 5'b00001, 5'b0, 1'b1, 5'b00010, 5'b00000, 8'd0);
    step(1'b0, 5'b00001, 5'b0, 1'b1, 5'b00001, 5'b00001, 8'd0);
    step(1'b0, 5'b00001, 5'b0, 1'b1, 5'b00001, 5'b00001, 8'd0);
    step(1'b0, 5'b00000, 5'b0, 1'b1, 5'b00001, 5'b00000, 8'd0);
    step(1'b0, 5'b00000, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);
    step(1'b0, 5'b00000, 5'b0, 1'b1, 5'b00000, 5'b00000, 8'd0);

    done = 1'b1;
  end

endmodule
